car_sensor_pattern_gen: RTL and testbench

- Emulates the two-beam gate sensor pair (sensor_a outer, sensor_b inner) for a car entering or leaving.
- On each accepted request, drives the full-passage waveform on sensor_a/sensor_b.
- Used for on-board self-test and bench stimulus of the car-counting FSM. Its outputs connect straight to that FSM's sensor inputs.

---
 rtl/car_sensor_pattern_gen.sv | 156 +++++++++++++++
 tb/tb_car_sensor_pattern_gen.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/car_sensor_pattern_gen.sv
// Two-beam gate sensor emulator: plays an enter/exit passage waveform on request.
// Optional ABORT_PATTERN_EN adds req_abort for a PH1-then-gap backing-out sequence.
module car_sensor_pattern_gen #(
    parameter int DWELL_W    = 8,
    parameter int GAP_CYCLES = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic               req_dir,
    input  logic [DWELL_W-1:0] dwell,
`ifdef ABORT_PATTERN_EN
    input  logic               req_abort,
`endif
    output logic               sensor_a,
    output logic               sensor_b,
    output logic               busy,
    output logic               done
);

    localparam int GAP_N = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
    localparam int GAP_W = (GAP_N > 1) ? $clog2(GAP_N) : 1;
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(GAP_N - 1);
    localparam logic [DWELL_W-1:0] ONE = DWELL_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PH1  = 3'd1,
        S_PH2  = 3'd2,
        S_PH3  = 3'd3,
        S_GAP  = 3'd4
    } state_t;

    state_t             state_q, state_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [DWELL_W-1:0] dur_q, dur_d;
    logic [GAP_W-1:0]   gcnt_q, gcnt_d;
    logic               dir_q, dir_d;
    logic               a_q, a_d;
    logic               b_q, b_d;
    logic               done_q, done_d;
    logic               abort_q, abort_d;
    logic               abort_in;

`ifdef ABORT_PATTERN_EN
    assign abort_in = req_abort;
`else
    assign abort_in = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            dur_q   <= ONE;
            gcnt_q  <= '0;
            dir_q   <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            done_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dur_q   <= dur_d;
            gcnt_q  <= gcnt_d;
            dir_q   <= dir_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dur_d   = dur_q;
        gcnt_d  = gcnt_q;
        dir_d   = dir_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        abort_d = abort_q;
        case (state_q)
            S_IDLE: begin
                a_d = 1'b0;
                b_d = 1'b0;
                if (req_valid) begin
                    state_d = S_PH1;
                    dir_d   = req_dir;
                    abort_d = abort_in;
                    dur_d   = (dwell == '0) ? ONE : dwell;
                    cnt_d   = dur_d - ONE;
                    a_d     = ~req_dir;
                    b_d     = req_dir;
                end
            end
            S_PH1: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else if (abort_q) begin
                    state_d = S_GAP;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    done_d  = 1'b1;
                    gcnt_d  = GAP_LOAD;
                end else begin
                    state_d = S_PH2;
                    cnt_d   = dur_q - ONE;
                    a_d     = 1'b1;
                    b_d     = 1'b1;
                end
            end
            S_PH2: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    state_d = S_PH3;
                    cnt_d   = dur_q - ONE;
                    a_d     = dir_q;
                    b_d     = ~dir_q;
                end
            end
            S_PH3: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - ONE;
                end else begin
                    state_d = S_GAP;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    done_d  = 1'b1;
                    gcnt_d  = GAP_LOAD;
                end
            end
            S_GAP: begin
                if (gcnt_q != '0) gcnt_d = gcnt_q - 1'b1;
                else              state_d = S_IDLE;
            end
            default: begin
                // Unreachable encodings recover straight to a quiet idle gate.
                state_d = S_IDLE;
                a_d     = 1'b0;
                b_d     = 1'b0;
            end
        endcase
    end

    assign sensor_a  = a_q;
    assign sensor_b  = b_q;
    assign done      = done_q;
    assign busy      = (state_q != S_IDLE);
    assign req_ready = (state_q == S_IDLE);

endmodule

// File: tb/tb_car_sensor_pattern_gen.sv
// Bench for car_sensor_pattern_gen: queue-based passage model, beam-order car
// counter and directed vectors with literal expectations.
module tb_car_sensor_pattern_gen;

    localparam int GAP = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       req_valid = 1'b0;
    logic       req_dir = 1'b0;
    logic [7:0] dwell = 8'd0;
`ifdef ABORT_PATTERN_EN
    logic       req_abort = 1'b0;
`endif
    logic       req_ready, sensor_a, sensor_b, busy, done;

    car_sensor_pattern_gen #(.DWELL_W(8), .GAP_CYCLES(GAP)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_dir   (req_dir),
        .dwell     (dwell),
`ifdef ABORT_PATTERN_EN
        .req_abort (req_abort),
`endif
        .sensor_a  (sensor_a),
        .sensor_b  (sensor_b),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    task automatic chk(string nm, logic [31:0] got, logic [31:0] exp);
        vecs++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    // Expected cycle contents: {a, b, done, busy, ready}
    typedef logic [4:0] ent_t;
    localparam ent_t IDLE_E = 5'b00001;
    ent_t q[$];
    ent_t cur = IDLE_E;

    function automatic void build(logic dir, int d, logic ab);
        int n = (d == 0) ? 1 : d;
        for (int i = 0; i < n; i++) q.push_back({~dir, dir, 3'b010});
        if (!ab) begin
            for (int i = 0; i < n; i++) q.push_back({2'b11, 3'b010});
            for (int i = 0; i < n; i++) q.push_back({dir, ~dir, 3'b010});
        end
        for (int i = 0; i < GAP; i++) q.push_back({2'b00, (i == 0), 2'b10});
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            cur = IDLE_E;
        end else if (q.size() != 0) begin
            cur = q.pop_front();
        end else if (cur[0] && req_valid) begin
`ifdef ABORT_PATTERN_EN
            build(req_dir, int'(dwell), req_abort);
`else
            build(req_dir, int'(dwell), 1'b0);
`endif
            cur = q.pop_front();
        end else begin
            cur = IDLE_E;
        end
    end

    logic [1:0] prev = 2'b00;
    always @(negedge clk) begin
        chk("cycle", {sensor_a, sensor_b, done, busy, req_ready}, cur);
        if (!reset) chk("one_bit_step", ($countones({sensor_a, sensor_b} ^ prev) <= 1), 1);
        prev = {sensor_a, sensor_b};
    end

    // Reference car counter: a passage counts only if the beams went through
    // all three blocked patterns in order before clearing.
    logic [1:0] last = 2'b00;
    logic [1:0] hist[$];
    int car_in = 0;
    int car_out = 0;
    always @(negedge clk) begin
        if (reset) begin
            hist.delete();
            last = 2'b00;
        end else if ({sensor_a, sensor_b} != last) begin
            if ({sensor_a, sensor_b} == 2'b00) begin
                if (hist.size() == 3 && hist[0] == 2 && hist[1] == 3 && hist[2] == 1)
                    car_in++;
                else if (hist.size() == 3 && hist[0] == 1 && hist[1] == 3 && hist[2] == 2)
                    car_out++;
                hist.delete();
            end else begin
                hist.push_back({sensor_a, sensor_b});
            end
            last = {sensor_a, sensor_b};
        end
    end

    int cyc = 0;
    int acc_t[$];
    always @(posedge clk) begin
        cyc++;
        if (!reset && req_valid && req_ready) acc_t.push_back(cyc);
    end

    logic [1:0] cap_ab[0:15];
    logic       cap_d[0:15];
    logic       cap_r[0:15];

    task automatic go(logic dir, logic [7:0] dw, logic ab);
        req_valid = 1'b1;
        req_dir   = dir;
        dwell     = dw;
`ifdef ABORT_PATTERN_EN
        req_abort = ab;
`else
        if (ab) $display("abort request ignored in this build");
`endif
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic capture(int n);
        for (int i = 0; i < n; i++) begin
            cap_ab[i] = {sensor_a, sensor_b};
            cap_d[i]  = done;
            cap_r[i]  = req_ready;
            @(negedge clk);
        end
    endtask

    int e1[12] = '{2, 2, 2, 3, 3, 3, 1, 1, 1, 0, 0, 0};
    int e2[6]  = '{1, 3, 2, 0, 0, 0};
    int e3[6]  = '{2, 3, 1, 0, 0, 0};
    int n10, n11, n01, nacc;

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_state", {sensor_a, sensor_b, done, busy, req_ready}, 5'b00001);
        reset = 1'b0;
        @(negedge clk);

        go(1'b0, 8'd3, 1'b0);
        capture(12);
        for (int i = 0; i < 12; i++) chk($sformatf("t1_ab[%0d]", i), cap_ab[i], e1[i]);
        chk("t1_done9", cap_d[9], 1);
        chk("t1_done8", cap_d[8], 0);
        chk("t1_done10", cap_d[10], 0);
        chk("t1_ready10", cap_r[10], 0);
        chk("t1_ready11", cap_r[11], 1);
        chk("t1_car_in", car_in, 1);
        chk("t1_car_out", car_out, 0);

        go(1'b1, 8'd1, 1'b0);
        capture(6);
        for (int i = 0; i < 6; i++) chk($sformatf("t2_ab[%0d]", i), cap_ab[i], e2[i]);
        chk("t2_done3", cap_d[3], 1);
        chk("t2_car_out", car_out, 1);

        go(1'b0, 8'd0, 1'b0);
        capture(6);
        for (int i = 0; i < 6; i++) chk($sformatf("t3_ab[%0d]", i), cap_ab[i], e3[i]);
        chk("t3_car_in", car_in, 2);

        go(1'b0, 8'd255, 1'b0);
        n10 = 0; n11 = 0; n01 = 0;
        for (int i = 0; i < 800; i++) begin
            if ({sensor_a, sensor_b} == 2'b10) n10++;
            if ({sensor_a, sensor_b} == 2'b11) n11++;
            if ({sensor_a, sensor_b} == 2'b01) n01++;
            @(negedge clk);
        end
        chk("t3_ph1_len", n10, 255);
        chk("t3_ph2_len", n11, 255);
        chk("t3_ph3_len", n01, 255);

        acc_t.delete();
        req_valid = 1'b1;
        dwell = 8'd2;
        for (int i = 0; i < 4; i++) begin
            req_dir = i[0];
            repeat (9) @(negedge clk);
        end
        req_valid = 1'b0;
        repeat (4) @(negedge clk);
        nacc = acc_t.size();
        chk("t4_accepts", nacc, 4);
        for (int i = 1; i < nacc; i++)
            chk($sformatf("t4_period[%0d]", i), acc_t[i] - acc_t[i-1], 9);
        chk("t4_car_in", car_in, 5);
        chk("t4_car_out", car_out, 3);

        go(1'b0, 8'd3, 1'b0);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #2 reset = 1'b1;
        #1;
        chk("t5_async_ab", {sensor_a, sensor_b}, 0);
        chk("t5_no_done", done, 0);
        chk("t5_not_busy", busy, 0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("t5_ready", req_ready, 1);
        repeat (14) @(negedge clk);
        chk("t5_car_in", car_in, 5);

`ifdef ABORT_PATTERN_EN
        go(1'b0, 8'd4, 1'b1);
        capture(7);
        for (int i = 0; i < 7; i++)
            chk($sformatf("t6_ab[%0d]", i), cap_ab[i], (i < 4) ? 2 : 0);
        chk("t6_done4", cap_d[4], 1);
        chk("t6_car_in", car_in, 5);
        chk("t6_car_out", car_out, 3);
        req_abort = 1'b0;
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
